// File: rtl/vend_actuator_sequencer.sv
// Actuator sequencer for the two-product vending FSM: stretches single-cycle
// vend/change requests into timed motor and coin-ejector pulses, tracks stock and tube.
module vend_actuator_sequencer #(
   parameter int MOTOR_CYCLES = 4,
   parameter int EJECT_CYCLES = 2,
   parameter int GAP_CYCLES   = 1,
   parameter int STOCK_INIT   = 8,
   parameter int COIN_INIT    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       vend_a,
   input  logic       vend_b,
   input  logic [1:0] change_in,
   input  logic       coin5_in,
   input  logic       restock,
   output logic       motor_a,
   output logic       motor_b,
   output logic       eject_5,
   output logic       busy,
   output logic       done,
   output logic       sold_out,
   output logic       change_fault,
   output logic [3:0] stock_a,
   output logic [3:0] stock_b,
   output logic [3:0] coins5,
   output logic       empty_a,
   output logic       empty_b,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MOTOR = 3'd1,
      S_GAP   = 3'd2,
      S_EJECT = 3'd3,
      S_EJGAP = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [7:0] MOTOR_LAST = 8'(MOTOR_CYCLES - 1);
   localparam logic [7:0] EJECT_LAST = 8'(EJECT_CYCLES - 1);
   localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
   localparam logic [3:0] STOCK_RST  = 4'(STOCK_INIT);
   localparam logic [3:0] COIN_RST   = 4'(COIN_INIT);

   state_t     state;
   state_t     next_state;
   logic [7:0] cnt;
   logic [7:0] next_cnt;
   logic       prod;         // 0 = product A, 1 = product B
   logic [1:0] coins_left;
   logic       short_flag;

   logic       req;
   logic       sel_b;
   logic [3:0] sel_stock;
   logic       accept;
   logic       reject;
   logic       do_restock;
   logic [1:0] req_coins;
   logic       enter_eject;
   logic       tube_dec;
   logic       short_set;

   logic       motor_a_d;
   logic       motor_b_d;
   logic       eject_d;
   logic       busy_d;
   logic       done_d;
   logic       sold_d;
   logic       fault_d;
   logic       prod_next;

   // A wins a simultaneous request; the stock test uses the winner's counter.
   assign req        = vend_a | vend_b;
   assign sel_b      = ~vend_a;
   assign sel_stock  = vend_a ? stock_a : stock_b;
   assign accept     = (state == S_IDLE) && req && (sel_stock != 4'd0);
   assign reject     = (state == S_IDLE) && req && (sel_stock == 4'd0);
   assign do_restock = (state == S_IDLE) && !req && restock;
   assign req_coins  = (change_in == 2'b01) ? 2'd1 :
                       (change_in == 2'b10) ? 2'd2 : 2'd0;

   // Tube is checked and debited on the edge that enters EJECT.
   assign enter_eject = (next_state == S_EJECT) && (state != S_EJECT);
   assign tube_dec    = enter_eject && (coins5 != 4'd0);
   assign short_set   = enter_eject && (coins5 == 4'd0);

   assign empty_a   = (stock_a == 4'd0);
   assign empty_b   = (stock_b == 4'd0);
   assign dbg_state = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= 8'd0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
      end
   end

   always_comb begin
      next_state = state;
      next_cnt   = cnt + 8'd1;
      case (state)
         S_IDLE: begin
            next_cnt = 8'd0;
            if (accept) next_state = S_MOTOR;
         end
         S_MOTOR: begin
            if (cnt == MOTOR_LAST) begin
               next_state = S_GAP;
               next_cnt   = 8'd0;
            end
         end
         S_GAP, S_EJGAP: begin
            if (cnt == GAP_LAST) begin
               next_state = (coins_left != 2'd0) ? S_EJECT : S_DONE;
               next_cnt   = 8'd0;
            end
         end
         S_EJECT: begin
            if (short_flag) begin
               next_state = S_DONE;
               next_cnt   = 8'd0;
            end else if (cnt == EJECT_LAST) begin
               next_state = S_EJGAP;
               next_cnt   = 8'd0;
            end
         end
         S_DONE: begin
            next_state = S_IDLE;
            next_cnt   = 8'd0;
         end
         default: begin
            next_state = S_IDLE;
            next_cnt   = 8'd0;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered below.
   always_comb begin
      prod_next = (state == S_IDLE) ? sel_b : prod;
      motor_a_d = (next_state == S_MOTOR) && !prod_next;
      motor_b_d = (next_state == S_MOTOR) && prod_next;
      eject_d   = (next_state == S_EJECT) && !short_set;
      busy_d    = (next_state != S_IDLE);
      done_d    = (next_state == S_DONE);
      fault_d   = (next_state == S_DONE) && short_flag;
      sold_d    = reject;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prod         <= 1'b0;
         coins_left   <= 2'd0;
         short_flag   <= 1'b0;
         stock_a      <= STOCK_RST;
         stock_b      <= STOCK_RST;
         coins5       <= COIN_RST;
         motor_a      <= 1'b0;
         motor_b      <= 1'b0;
         eject_5      <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         sold_out     <= 1'b0;
         change_fault <= 1'b0;
      end else begin
         motor_a      <= motor_a_d;
         motor_b      <= motor_b_d;
         eject_5      <= eject_d;
         busy         <= busy_d;
         done         <= done_d;
         sold_out     <= sold_d;
         change_fault <= fault_d;

         if (accept) begin
            prod       <= sel_b;
            coins_left <= req_coins;
         end else if (tube_dec) begin
            coins_left <= coins_left - 2'd1;
         end

         if (short_set) short_flag <= 1'b1;
         else if (state == S_DONE) short_flag <= 1'b0;

         if (accept && !sel_b) stock_a <= stock_a - 4'd1;
         else if (do_restock) stock_a <= STOCK_RST;

         if (accept && sel_b) stock_b <= stock_b - 4'd1;
         else if (do_restock) stock_b <= STOCK_RST;

         // A deposit and a debit in the same cycle cancel out.
         case ({coin5_in, tube_dec})
            2'b10:   if (coins5 != 4'd15) coins5 <= coins5 + 4'd1;
            2'b01:   coins5 <= coins5 - 4'd1;
            default: coins5 <= coins5;
         endcase
      end
   end

endmodule

// File: tb/tb_vend_actuator_sequencer.sv
// Bench for vend_actuator_sequencer: directed scenarios plus random traffic,
// checked cycle by cycle against a timeline model of each vend.
module tb_vend_actuator_sequencer;

   localparam int M  = 4;
   localparam int E  = 2;
   localparam int G  = 1;
   localparam int SI = 8;
   localparam int CI = 4;
   localparam logic [20:0] INIT_VEC = {7'b0, 4'(SI), 4'(SI), 4'(CI), 2'b00};

   logic       clk = 1'b0;
   logic       reset;
   logic       vend_a, vend_b, coin5_in, restock;
   logic [1:0] change_in;
   logic       motor_a, motor_b, eject_5, busy, done, sold_out, change_fault;
   logic [3:0] stock_a, stock_b, coins5;
   logic       empty_a, empty_b;
   logic [2:0] dbg_state;

   int checks   = 0;
   int failures = 0;

   // Reference model: each vend is a timeline indexed by cycles since acceptance.
   int m_stock[2];
   int m_coins;
   bit m_busy;
   int m_t, m_done_t, m_n;
   bit m_prod, m_short;
   bit e_ma, e_mb, e_ej, e_done, e_sold, e_fault;

   vend_actuator_sequencer #(
      .MOTOR_CYCLES(M), .EJECT_CYCLES(E), .GAP_CYCLES(G),
      .STOCK_INIT(SI), .COIN_INIT(CI)
   ) dut (
      .clk(clk), .reset(reset), .vend_a(vend_a), .vend_b(vend_b),
      .change_in(change_in), .coin5_in(coin5_in), .restock(restock),
      .motor_a(motor_a), .motor_b(motor_b), .eject_5(eject_5), .busy(busy),
      .done(done), .sold_out(sold_out), .change_fault(change_fault),
      .stock_a(stock_a), .stock_b(stock_b), .coins5(coins5),
      .empty_a(empty_a), .empty_b(empty_b), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   function automatic logic [20:0] dut_vec();
      return {motor_a, motor_b, eject_5, busy, done, sold_out, change_fault,
              stock_a, stock_b, coins5, empty_a, empty_b};
   endfunction

   function automatic logic [20:0] exp_vec();
      return {e_ma, e_mb, e_ej, m_busy, e_done, e_sold, e_fault,
              4'(m_stock[0]), 4'(m_stock[1]), 4'(m_coins),
              m_stock[0] == 0, m_stock[1] == 0};
   endfunction

   task automatic model_reset();
      m_stock[0] = SI; m_stock[1] = SI; m_coins = CI;
      m_busy = 0; m_t = 0; m_done_t = 0; m_n = 0; m_prod = 0; m_short = 0;
      e_ma = 0; e_mb = 0; e_ej = 0; e_done = 0; e_sold = 0; e_fault = 0;
   endtask

   task automatic model_edge();
      int s, r, sel;
      bit dec;
      e_ma = 0; e_mb = 0; e_ej = 0; e_done = 0; e_sold = 0; e_fault = 0;
      dec = 0;
      if (!m_busy) begin
         if (vend_a || vend_b) begin
            sel = vend_a ? 0 : 1;
            if (m_stock[sel] == 0) e_sold = 1;
            else begin
               m_stock[sel]--;
               m_busy = 1; m_t = 0; m_prod = (sel == 1); m_short = 0;
               m_n = (change_in == 2'b01) ? 1 : (change_in == 2'b10) ? 2 : 0;
               m_done_t = M + G + 1 + m_n * (E + G);
            end
         end else if (restock) begin
            m_stock[0] = SI; m_stock[1] = SI;
         end
      end else if (m_t == m_done_t) begin
         m_busy = 0;
      end
      if (m_busy) begin
         m_t++;
         s = M + G + 1;
         if (m_t <= M) begin
            if (m_prod) e_mb = 1; else e_ma = 1;
         end
         if (m_t >= s && m_t < m_done_t) begin
            r = (m_t - s) % (E + G);
            if (r == 0) begin
               if (m_coins == 0) begin m_short = 1; m_done_t = m_t + 1; end
               else dec = 1;
            end
            e_ej = !m_short && (r < E);
         end
         e_done  = (m_t == m_done_t);
         e_fault = e_done && m_short;
      end
      if (coin5_in && !dec) begin
         if (m_coins < 15) m_coins++;
      end else if (!coin5_in && dec) begin
         m_coins--;
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic clear_inputs();
      vend_a = 0; vend_b = 0; change_in = 2'b00; coin5_in = 0; restock = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1;
      model_reset();
      #12;
      checks++;
      if (dut_vec() !== INIT_VEC) begin
         failures++;
         $display("FAIL reset_state got=%h want=%h", dut_vec(), INIT_VEC);
      end
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_vend_a_plain();
      int done_at, motor_cnt;
      bit ej_seen;
      do_reset();
      done_at = -1; motor_cnt = 0; ej_seen = 0;
      vend_a = 1;
      for (int c = 1; c <= 8; c++) begin
         cycle();
         vend_a = 0;
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL vend_a_plain cyc=%0d got=%h want=%h", c, dut_vec(), exp_vec());
         end
         if (done === 1'b1) done_at = c;
         if (motor_a === 1'b1) motor_cnt++;
         if (eject_5 === 1'b1) ej_seen = 1;
      end
      checks++;
      if (done_at != 6) begin failures++; $display("FAIL vend_a_done_time got=%0d want=6", done_at); end
      checks++;
      if (motor_cnt != 4) begin failures++; $display("FAIL vend_a_motor_len got=%0d want=4", motor_cnt); end
      checks++;
      if (stock_a !== 4'd7) begin failures++; $display("FAIL vend_a_stock got=%0d want=7", stock_a); end
      checks++;
      if (ej_seen) begin failures++; $display("FAIL vend_a_no_eject got=1 want=0"); end
   endtask

   task automatic test_change_10();
      int done_at, ej_cnt, motor_cnt;
      bit fault_seen;
      do_reset();
      done_at = -1; ej_cnt = 0; motor_cnt = 0; fault_seen = 0;
      vend_b = 1; change_in = 2'b10;
      for (int c = 1; c <= 14; c++) begin
         cycle();
         vend_b = 0; change_in = 2'b00;
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL change_10 cyc=%0d got=%h want=%h", c, dut_vec(), exp_vec());
         end
         if (done === 1'b1) done_at = c;
         if (eject_5 === 1'b1) ej_cnt++;
         if (motor_b === 1'b1) motor_cnt++;
         if (change_fault === 1'b1) fault_seen = 1;
      end
      checks++;
      if (done_at != 12) begin failures++; $display("FAIL change_10_done_time got=%0d want=12", done_at); end
      checks++;
      if (ej_cnt != 4) begin failures++; $display("FAIL change_10_eject_cycles got=%0d want=4", ej_cnt); end
      checks++;
      if (motor_cnt != 4) begin failures++; $display("FAIL change_10_motor_len got=%0d want=4", motor_cnt); end
      checks++;
      if (coins5 !== 4'd2) begin failures++; $display("FAIL change_10_coins got=%0d want=2", coins5); end
      checks++;
      if (fault_seen) begin failures++; $display("FAIL change_10_fault got=1 want=0"); end
   endtask

   task automatic test_short_change();
      int done_at, fault_at, ej_cnt;
      do_reset();
      for (int v = 0; v < 3; v++) begin
         vend_a = 1; change_in = 2'b01;
         for (int c = 1; c <= 10; c++) begin
            cycle();
            vend_a = 0; change_in = 2'b00;
            checks++;
            if (dut_vec() !== exp_vec()) begin
               failures++;
               $display("FAIL short_prep v=%0d cyc=%0d got=%h want=%h", v, c, dut_vec(), exp_vec());
            end
         end
      end
      checks++;
      if (coins5 !== 4'd1) begin failures++; $display("FAIL short_prep_coins got=%0d want=1", coins5); end
      done_at = -1; fault_at = -1; ej_cnt = 0;
      vend_a = 1; change_in = 2'b10;
      for (int c = 1; c <= 12; c++) begin
         cycle();
         vend_a = 0; change_in = 2'b00;
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL short_change cyc=%0d got=%h want=%h", c, dut_vec(), exp_vec());
         end
         if (done === 1'b1) done_at = c;
         if (change_fault === 1'b1) fault_at = c;
         if (eject_5 === 1'b1) ej_cnt++;
      end
      checks++;
      if (done_at != 10 || fault_at != 10) begin
         failures++;
         $display("FAIL short_done_fault got=%0d/%0d want=10/10", done_at, fault_at);
      end
      checks++;
      if (ej_cnt != 2) begin failures++; $display("FAIL short_eject_cycles got=%0d want=2", ej_cnt); end
      checks++;
      if (coins5 !== 4'd0) begin failures++; $display("FAIL short_coins got=%0d want=0", coins5); end
   endtask

   task automatic test_sold_out();
      do_reset();
      for (int v = 0; v < 8; v++) begin
         vend_a = 1;
         for (int c = 1; c <= 7; c++) begin
            cycle();
            vend_a = 0;
            checks++;
            if (dut_vec() !== exp_vec()) begin
               failures++;
               $display("FAIL drain v=%0d cyc=%0d got=%h want=%h", v, c, dut_vec(), exp_vec());
            end
         end
      end
      vend_a = 1;
      cycle();
      vend_a = 0;
      checks++;
      if ({sold_out, busy, stock_a, empty_a} !== {1'b1, 1'b0, 4'd0, 1'b1}) begin
         failures++;
         $display("FAIL sold_out_pulse got=%b want=1_0_0000_1", {sold_out, busy, stock_a, empty_a});
      end
      cycle();
      checks++;
      if ({sold_out, busy, motor_a} !== 3'b000) begin
         failures++;
         $display("FAIL sold_out_after got=%b want=000", {sold_out, busy, motor_a});
      end
      restock = 1;
      cycle();
      restock = 0;
      checks++;
      if ({stock_a, stock_b, empty_a} !== {4'd8, 4'd8, 1'b0}) begin
         failures++;
         $display("FAIL restock got=%0d/%0d want=8/8", stock_a, stock_b);
      end
   endtask

   task automatic test_simultaneous();
      bit mb_seen;
      do_reset();
      mb_seen = 0;
      vend_a = 1; vend_b = 1;
      for (int c = 1; c <= 8; c++) begin
         cycle();
         vend_a = 0;
         vend_b = (c == 2);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL simultaneous cyc=%0d got=%h want=%h", c, dut_vec(), exp_vec());
         end
         if (motor_b === 1'b1) mb_seen = 1;
      end
      checks++;
      if (mb_seen || stock_b !== 4'd8 || stock_a !== 4'd7) begin
         failures++;
         $display("FAIL simultaneous_winner got=mb%0d a%0d b%0d want=mb0 a7 b8", mb_seen, stock_a, stock_b);
      end
   endtask

   task automatic test_coin_collision();
      bit ej_seen;
      do_reset();
      ej_seen = 0;
      vend_a = 1; change_in = 2'b01;
      for (int c = 1; c <= 10; c++) begin
         coin5_in = (c == 6);
         cycle();
         vend_a = 0; change_in = 2'b00; coin5_in = 0;
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL collision cyc=%0d got=%h want=%h", c, dut_vec(), exp_vec());
         end
         if (eject_5 === 1'b1) ej_seen = 1;
      end
      checks++;
      if (coins5 !== 4'd4 || !ej_seen) begin
         failures++;
         $display("FAIL collision_coins got=%0d ej=%0d want=4 ej=1", coins5, ej_seen);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int c = 1; c <= 14; c++) begin
         coin5_in = 1;
         cycle();
         coin5_in = 0;
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL saturation cyc=%0d got=%h want=%h", c, dut_vec(), exp_vec());
         end
      end
      checks++;
      if (coins5 !== 4'd15) begin failures++; $display("FAIL saturation_value got=%0d want=15", coins5); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      vend_b = 1; change_in = 2'b10;
      for (int c = 1; c <= 7; c++) begin
         cycle();
         vend_b = 0; change_in = 2'b00;
      end
      checks++;
      if (eject_5 !== 1'b1) begin failures++; $display("FAIL reset_mid_setup eject got=%b want=1", eject_5); end
      reset = 1;
      #1;
      model_reset();
      checks++;
      if (dut_vec() !== INIT_VEC) begin
         failures++;
         $display("FAIL reset_mid got=%h want=%h", dut_vec(), INIT_VEC);
      end
      @(negedge clk);
      reset = 0;
      for (int c = 1; c <= 3; c++) begin
         cycle();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_mid_after cyc=%0d got=%h want=%h", c, dut_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 1; c <= 800; c++) begin
         vend_a    = ($urandom_range(0, 5) == 0);
         vend_b    = ($urandom_range(0, 5) == 0);
         change_in = 2'($urandom_range(0, 3));
         coin5_in  = ($urandom_range(0, 7) == 0);
         restock   = ($urandom_range(0, 39) == 0);
         cycle();
         clear_inputs();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL random cyc=%0d got=%h want=%h", c, dut_vec(), exp_vec());
         end
      end
   endtask

   initial begin
      clear_inputs();
      reset = 1;
      model_reset();
      test_reset();
      test_vend_a_plain();
      test_change_10();
      test_short_change();
      test_sold_out();
      test_simultaneous();
      test_coin_collision();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
